v1_reg_queue_ctrl: RTL and testbench
====================================

Name: v1_reg_queue_ctrl

Overview:
- Control unit for the shift-register queue datapath. The datapath is p_depth registers; each register either loads the shared write bus or shifts from its lower-index neighbour.
- This block owns occupancy and the enqueue/dequeue val/rdy handshakes. It drives the per-register write-select and shift-enable arrays so the datapath behaves as a FIFO.
- The oldest entry always sits at index p_depth-1, so the dequeue message is the datapath's data_out[p_depth-1]. This block carries no data.

Parameters:
- p_depth, 32, number of queue registers; must be >= 2.
- p_idwidth, $clog2(p_depth), register index width.
- p_cntwidth, $clog2(p_depth+1), occupancy counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- enq_val  input  1  producer has a message on the datapath write bus.
- enq_rdy  output  1  block can accept an enqueue this cycle.
- deq_val  output  1  data_out[p_depth-1] holds a valid oldest entry.
- deq_rdy  input  1  consumer takes the oldest entry this cycle.
- flush  input  1  synchronous discard of all entries.
- wr_data  output  1 x p_depth (unpacked array)  per-register write-bus load select.
- shift_en  output  1 x p_depth (unpacked array)  per-register shift-from-(i-1) enable.
- count  output  p_cntwidth  current occupancy, 0..p_depth.
- full  output  1  count == p_depth.
- empty  output  1  count == 0.

Behaviour:
- State is the count register only.
- Reset: count=0. While rst is high, enq_rdy=0, deq_val=0, and all wr_data and shift_en bits are 0. After reset: empty=1, full=0, enq_rdy=1.
- Handshake signals:
  - enq_rdy = !full && !rst, with no full-queue pass-through.
  - deq_val = !empty && !rst.
  - enq_fire = enq_val && enq_rdy.
  - deq_fire = deq_val && deq_rdy.
- Valid region: entries occupy indices [p_depth-count, p_depth-1]. Age decreases with decreasing index.
- All control outputs are combinational from count, enq_fire, deq_fire and flush. The datapath registers them on the same edge that count updates.
- enq_fire only: wr_data[p_depth-1-count]=1, all shift_en=0, count+1.
- deq_fire only: shift_en[i]=1 for i in [p_depth-count+1, p_depth-1], all other shift_en=0, wr_data all 0, count-1. With count==1 no shift_en bit is set; the entry is simply invalidated.
- enq_fire and deq_fire together:
  - shift_en as in the deq-only case.
  - wr_data[p_depth-count]=1, the post-shift tail.
  - count unchanged.
  - The written index is never shift-enabled.
- Invariants:
  - wr_data is one-hot or zero.
  - For every i, wr_data[i] && shift_en[i] is never true.
  - No index below p_depth-count is ever shift-enabled.
- flush: highest priority. All wr_data/shift_en forced 0 and next count=0, whatever enq_val/deq_rdy are. enq_rdy and deq_val still follow count that cycle, but no fire is counted or acknowledged: when flush is high, enq_fire and deq_fire are forced 0.
- Full: enq_rdy=0, so an enqueue is refused even if a dequeue fires in the same cycle. Empty: deq_val=0, with no bypass; enqueue-to-deq_val latency is 1 cycle.
- Counter never wraps. Overflow and underflow are unreachable through the handshake; an assertion flags count>p_depth.
- Reset mid-operation: count clears immediately and asynchronously; the in-flight transaction is dropped. Register contents are don't-care.

Test Plan (p_depth=4):
- Reset, then enq_val=1 for 4 cycles with msgs A,B,C,D:
  - wr_data index sequence 3,2,1,0.
  - count goes 1,2,3,4, then full=1 and enq_rdy=0.
  - A appears at data_out[3].
- Full queue A..D, deq_rdy=1 for 4 cycles:
  - first shift_en={1,2,3}, then {2,3}, {3}, none.
  - deq sequence A,B,C,D; then empty=1, deq_val=0.
- count=2, enq_fire and deq_fire together:
  - shift_en={3}, wr_data[2]=1, count stays 2.
  - order preserved across 6 such cycles with streaming input.
- count=1, simultaneous enq/deq: shift_en none, wr_data[3]=1, count=1, new msg next at data_out[3].
- count=3, flush=1 with enq_val=1 and deq_rdy=1: no wr_data/shift_en bits set, count=0 next cycle, no fire acknowledged.
- rst asserted mid-stream at count=2 between clock edges:
  - count=0 and enq_rdy=0 immediately; deq_val=0 while rst is high.
  - After release, enq_rdy=1 and the enqueue writes index 3.
- Random enq_val/deq_rdy for 10k cycles against a reference FIFO model: order matches, invariants hold every cycle.

Source files
------------

// File: rtl/v1_reg_queue_ctrl.sv
// Occupancy and enqueue/dequeue handshake control for a shift-register FIFO datapath.
// The oldest entry always sits at index p_depth-1; this block only steers loads and shifts.
module v1_reg_queue_ctrl_chk #(
    parameter int p_depth    = 32,
    parameter int p_cntwidth = $clog2(p_depth + 1)
) (
    input logic                  clk,
    input logic                  rst,
    input logic [p_cntwidth-1:0] count
);
    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= p_cntwidth'(p_depth));
endmodule

module v1_reg_queue_ctrl #(
    parameter int p_depth    = 32,
    parameter int p_idwidth  = $clog2(p_depth),
    parameter int p_cntwidth = $clog2(p_depth + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enq_val,
    output logic                  enq_rdy,
    output logic                  deq_val,
    input  logic                  deq_rdy,
    input  logic                  flush,
    output logic                  wr_data  [p_depth],
    output logic                  shift_en [p_depth],
    output logic [p_cntwidth-1:0] count,
    output logic                  full,
    output logic                  empty
);
    localparam logic [p_cntwidth-1:0] lp_full = p_cntwidth'(p_depth);
    localparam logic [p_cntwidth-1:0] lp_one  = p_cntwidth'(1);
    localparam logic [p_cntwidth-1:0] lp_zero = {p_cntwidth{1'b0}};

    logic [p_cntwidth-1:0] count_q;
    logic [p_cntwidth-1:0] count_d;
    logic                  enq_fire_s;
    logic                  deq_fire_s;
    logic                  wr_en_s;
    logic                  shift_on_s;
    logic [p_idwidth-1:0]  wr_idx_s;
    int                    shift_lo_s;

    // Occupancy register; reset drops any in-flight transaction immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= lp_zero;
        end else begin
            count_q <= count_d;
        end
    end

    assign full       = (count_q == lp_full);
    assign empty      = (count_q == lp_zero);
    assign enq_rdy    = !full && !rst;
    assign deq_val    = !empty && !rst;
    assign enq_fire_s = enq_val && enq_rdy && !flush;
    assign deq_fire_s = deq_val && deq_rdy && !flush;
    assign count      = count_q;
    // Lowest index that shifts on a dequeue; the head slot itself just gets overwritten.
    assign shift_lo_s = p_depth - int'(count_q) + 1;

    // Next occupancy and which single register (if any) loads the write bus.
    always_comb begin
        count_d    = count_q;
        wr_en_s    = 1'b0;
        shift_on_s = 1'b0;
        wr_idx_s   = {p_idwidth{1'b0}};
        if (flush) begin
            count_d = lp_zero;
        end else begin
            case ({enq_fire_s, deq_fire_s})
                2'b10: begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = p_idwidth'(p_depth - 1 - int'(count_q));
                    count_d  = count_q + lp_one;
                end
                2'b01: begin
                    shift_on_s = 1'b1;
                    count_d    = count_q - lp_one;
                end
                2'b11: begin
                    // The valid region slides up by one, so the new tail lands one slot higher.
                    shift_on_s = 1'b1;
                    wr_en_s    = 1'b1;
                    wr_idx_s   = p_idwidth'(p_depth - int'(count_q));
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // Expand the load index and shift window into per-register enables.
    always_comb begin
        for (int i = 0; i < p_depth; i++) begin
            wr_data[i]  = wr_en_s && (wr_idx_s == p_idwidth'(i));
            shift_en[i] = shift_on_s && (i >= shift_lo_s);
        end
    end

    v1_reg_queue_ctrl_chk #(
        .p_depth   (p_depth),
        .p_cntwidth(p_cntwidth)
    ) u_chk (
        .clk  (clk),
        .rst  (rst),
        .count(count_q)
    );
endmodule

// File: tb/tb_v1_reg_queue_ctrl.sv
// Self-checking bench for v1_reg_queue_ctrl at depth 4: a FIFO reference model plus a
// datapath model driven by the DUT's enables, with directed literal checks and a random soak.
module tb_v1_reg_queue_ctrl;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enq_val;
    logic       deq_rdy;
    logic       flush;
    logic       enq_rdy;
    logic       deq_val;
    logic       full;
    logic       empty;
    logic       wr_data  [D];
    logic       shift_en [D];
    logic [2:0] count;
    logic [3:0] wr_vec;
    logic [3:0] sh_vec;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         q[$];
    int         dp[D];
    int         bus;
    int         next_msg;
    logic [3:0] snap_wr;
    logic [3:0] snap_sh;
    int         snap_bus;
    bit         snap_ef;
    bit         snap_df;
    bit         snap_flush;

    always #5 clk = ~clk;

    v1_reg_queue_ctrl #(.p_depth(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .enq_val (enq_val),
        .enq_rdy (enq_rdy),
        .deq_val (deq_val),
        .deq_rdy (deq_rdy),
        .flush   (flush),
        .wr_data (wr_data),
        .shift_en(shift_en),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        for (int i = 0; i < D; i++) begin
            wr_vec[i] = wr_data[i];
            sh_vec[i] = shift_en[i];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the reference FIFO.
    task automatic check_all();
        int         cnt;
        bit         er;
        bit         dv;
        bit         ef;
        bit         df;
        int         ok;
        logic [3:0] ew;
        logic [3:0] es;
        if (rst) q.delete();
        cnt = q.size();
        er  = !rst && (cnt < D);
        dv  = !rst && (cnt > 0);
        ef  = enq_val && er && !flush;
        df  = deq_rdy && dv && !flush;
        ew  = 4'b0000;
        es  = 4'b0000;
        if (ef) ew[df ? (D - cnt) : (D - 1 - cnt)] = 1'b1;
        if (df) for (int i = D - cnt + 1; i < D; i++) es[i] = 1'b1;
        chk("m_count", int'(count), cnt);
        chk("m_full", int'(full), int'(cnt == D));
        chk("m_empty", int'(empty), int'(cnt == 0));
        chk("m_enq_rdy", int'(enq_rdy), int'(er));
        chk("m_deq_val", int'(deq_val), int'(dv));
        chk("m_wr_data", int'(wr_vec), int'(ew));
        chk("m_shift_en", int'(sh_vec), int'(es));
        if (!rst) begin
            ok = 1;
            for (int k = 0; k < cnt; k++) if (dp[D-1-k] != q[k]) ok = 0;
            chk("m_order", ok, 1);
        end
        snap_wr    = wr_vec;
        snap_sh    = sh_vec;
        snap_bus   = bus;
        snap_ef    = ef;
        snap_df    = df;
        snap_flush = flush;
    endtask

    task automatic update_model();
        int nd[D];
        if (!rst) begin
            for (int i = 0; i < D; i++) begin
                if (snap_wr[i]) nd[i] = snap_bus;
                else if (snap_sh[i] && i > 0) nd[i] = dp[i-1];
                else nd[i] = dp[i];
            end
            dp = nd;
            if (snap_flush) begin
                q.delete();
            end else begin
                if (snap_df) void'(q.pop_front());
                if (snap_ef) q.push_back(snap_bus);
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic drive(input logic e, input logic d, input logic f, input int b);
        enq_val = e;
        deq_rdy = d;
        flush   = f;
        bus     = b;
    endtask

    initial begin
        int exp_sh[4];
        exp_sh = '{14, 12, 8, 0};
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < D; i++) dp[i] = 0;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_enq_rdy", int'(enq_rdy), 1);

        // Fill with A..D (10..13): tail index 3,2,1,0.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, 10 + k);
            #1;
            chk("fill_wr_idx", int'(wr_vec), 8 >> k);
            cycle();
            chk("fill_count", int'(count), k + 1);
        end
        drive(1'b0, 1'b0, 1'b0, 0);
        #1;
        chk("fill_full", int'(full), 1);
        chk("fill_enq_rdy", int'(enq_rdy), 0);
        chk("fill_head", dp[3], 10);

        // Drain: shift windows {1,2,3},{2,3},{3},none and order A..D.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 1'b0, 0);
            #1;
            chk("drain_shift", int'(sh_vec), exp_sh[k]);
            chk("drain_head", dp[3], 10 + k);
            cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 0);
        #1;
        chk("drain_empty", int'(empty), 1);
        chk("drain_deq_val", int'(deq_val), 0);

        // Streaming at count=2.
        drive(1'b1, 1'b0, 1'b0, 20);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 21);
        cycle();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b1, 1'b0, 22 + k);
            #1;
            chk("both2_shift", int'(sh_vec), 8);
            chk("both2_wr", int'(wr_vec), 4);
            chk("both2_head", dp[3], 20 + k);
            cycle();
            chk("both2_count", int'(count), 2);
        end

        // Simultaneous enq/deq at count=1.
        drive(1'b0, 1'b1, 1'b0, 0);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 40);
        #1;
        chk("both1_shift", int'(sh_vec), 0);
        chk("both1_wr", int'(wr_vec), 8);
        cycle();
        chk("both1_count", int'(count), 1);
        chk("both1_head", dp[3], 40);

        // Flush at count=3 with enq and deq requested.
        drive(1'b1, 1'b0, 1'b0, 41);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 42);
        cycle();
        drive(1'b1, 1'b1, 1'b1, 43);
        #1;
        chk("flush_wr", int'(wr_vec), 0);
        chk("flush_shift", int'(sh_vec), 0);
        chk("flush_enq_rdy", int'(enq_rdy), 1);
        chk("flush_deq_val", int'(deq_val), 1);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 0);
        #1;
        chk("flush_count", int'(count), 0);

        // Asynchronous reset mid-stream at count=2.
        drive(1'b1, 1'b0, 1'b0, 50);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 51);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 52);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_enq_rdy", int'(enq_rdy), 0);
        chk("arst_deq_val", int'(deq_val), 0);
        chk("arst_wr", int'(wr_vec), 0);
        cycle();
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 53);
        #1;
        chk("arst_rel_rdy", int'(enq_rdy), 1);
        chk("arst_rel_wr", int'(wr_vec), 8);
        cycle();
        chk("arst_rel_count", int'(count), 1);

        // Random soak against the reference model.
        next_msg = 100;
        for (int n = 0; n < 10000; n++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 63) == 0), next_msg);
            next_msg++;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
